mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with the architectural HI/LO register pair. It sits beside the ALU in the execute stage and takes the same two operands (rs value and rt value), but runs MULT/MULTU/DIV/DIVU iteratively over 32 cycles. While it runs, it signals `busy` so the pipeline control can stall MFHI/MFLO. MTHI/MTLO write HI/LO directly in a single cycle.

---
 rtl/mdu_pkg.sv | 11 +
 rtl/mdu_sign_fix.sv | 10 +
 rtl/mult_div_unit.sv | 90 +++++++++
 tb/tb_mult_div_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode, state and constant definitions for the multiply/divide unit
package mdu_pkg;
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   localparam logic [63:0] DIV0_LO = '1;
   typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negation, used for magnitudes and result fix-up
module mdu_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);
   assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply/divide with architectural HI/LO registers
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] read_data_1,
   input  logic [WIDTH-1:0] read_data_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e             r_state;
   logic               r_busy, r_done, r_div, r_neg_a, r_neg_b;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_hi, r_lo, r_a, r_q, r_m;
   logic               w_signed;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_a_nx, w_q_nx, w_quo, w_rem;
   logic [WIDTH:0]     w_sum, w_sh, w_diff;
   logic [2*WIDTH-1:0] w_prod;
   assign w_signed = ~md_op[0];
   mdu_sign_fix #(.W(WIDTH)) u_mag_a (.i_val(read_data_1), .i_neg(w_signed & read_data_1[WIDTH-1]), .o_val(w_mag_a));
   mdu_sign_fix #(.W(WIDTH)) u_mag_b (.i_val(read_data_2), .i_neg(w_signed & read_data_2[WIDTH-1]), .o_val(w_mag_b));
   // One iteration step: shift-add for multiply ({r_a,r_q} is the product), restoring step for divide
   always_comb begin
      w_sum  = {1'b0, r_a} + {1'b0, (r_q[0] ? r_m : {WIDTH{1'b0}})};
      w_sh   = {r_a, r_q[WIDTH-1]};
      w_diff = w_sh - {1'b0, r_m};
      w_a_nx = r_div ? (w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_sum[WIDTH:1];
      w_q_nx = r_div ? {r_q[WIDTH-2:0], ~w_diff[WIDTH]} : {w_sum[0], r_q[WIDTH-1:1]};
   end
   mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.i_val({w_a_nx, w_q_nx}), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_prod));
   mdu_sign_fix #(.W(WIDTH)) u_fix_quo (.i_val(w_q_nx), .i_neg(r_neg_a ^ r_neg_b), .o_val(w_quo));
   mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.i_val(w_a_nx), .i_neg(r_neg_a), .o_val(w_rem));
   // FSM: accept requests in IDLE, iterate in RUN, commit HI/LO on the last iteration
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_div   <= 1'b0;
         r_neg_a <= 1'b0;
         r_neg_b <= 1'b0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_a     <= '0;
         r_q     <= '0;
         r_m     <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            if (start && md_op == MD_MTHI) r_hi <= read_data_1;
            if (start && md_op == MD_MTLO) r_lo <= read_data_1;
            if (start && md_op <= MD_DIVU) begin
               r_state <= RUN;
               r_busy  <= 1'b1;
               r_div   <= md_op[1];
               r_neg_a <= w_signed & read_data_1[WIDTH-1];
               r_neg_b <= w_signed & read_data_2[WIDTH-1];
               r_cnt   <= CW'(WIDTH);
               r_a     <= '0;
               r_q     <= w_mag_a;
               r_m     <= w_mag_b;
            end
         end else begin
            r_a   <= w_a_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_hi    <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
               r_lo    <= r_div ? (r_m == '0 ? DIV0_LO[WIDTH-1:0] : w_quo) : w_prod[WIDTH-1:0];
            end
         end
      end
   end
   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench with directed multiply/divide vectors
module tb_mult_div_unit;
   import mdu_pkg::*;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, eh, el;
   } vec_t;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  md_op;
   logic [31:0] read_data_1, read_data_2, hi, lo;
   logic        busy, done;
   logic [63:0] exp_q[$];
   int          n_checks = 0, n_fail = 0, n_done = 0, exp_done = 0, run_len = 0;
   logic        prev_done = 1'b0;
   vec_t        vecs[9];

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .read_data_1(read_data_1), .read_data_2(read_data_2),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      start = 1'b1;
      md_op = op;
      read_data_1 = a;
      read_data_2 = b;
      if (op <= MD_DIVU) begin
         exp_q.push_back({eh, el});
         exp_done++;
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check({name, " done seen"}, {63'd0, got}, 64'd1);
   endtask

   // Monitor: compares every committed result against the scoreboard queue
   always @(negedge clk) begin
      if (reset) run_len = 0;
      else if (busy) run_len++;
      if (done) begin
         n_done++;
         check("done width", {63'd0, prev_done}, 64'd0);
         check("busy length", 64'(run_len), 64'd32);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected done: hi=%h lo=%h with no pending operation", hi, lo);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("result hi", {32'd0, hi}, {32'd0, e[63:32]});
            check("result lo", {32'd0, lo}, {32'd0, e[31:0]});
         end
         run_len = 0;
      end
      prev_done = done;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[2] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[3] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[6] = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
      vecs[7] = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
      vecs[8] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      reset = 1'b1;
      start = 1'b0;
      md_op = '0;
      read_data_1 = '0;
      read_data_2 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset hi", {32'd0, hi}, 64'd0);
      check("reset lo", {32'd0, lo}, 64'd0);
      check("reset busy/done", {62'd0, busy, done}, 64'd0);
      @(negedge clk);
      issue(MD_MTHI, 32'h1234, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("mthi hi", {32'd0, hi}, 64'h1234);
      check("mthi busy/done", {62'd0, busy, done}, 64'd0);
      issue(3'd6, 32'hABCD, 32'h1, 32'h0, 32'h0);
      @(negedge clk);
      check("reserved busy", {63'd0, busy}, 64'd0);
      check("reserved hi/lo", {hi, lo}, {32'h1234, 32'h0});
      for (int i = 0; i < 9; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
         wait_done($sformatf("vec%0d", i));
      end
      issue(MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);
      repeat (5) @(negedge clk);
      start = 1'b1;
      md_op = MD_MTLO;
      read_data_1 = 32'hDEAD;
      @(negedge clk);
      md_op = MD_MULT;
      read_data_1 = 32'd3;
      read_data_2 = 32'd3;
      @(negedge clk);
      start = 1'b0;
      check("run hi/lo hold", {hi, lo}, {vecs[8].eh, vecs[8].el});
      check("run busy", {63'd0, busy}, 64'd1);
      wait_done("interference");
      repeat (40) @(negedge clk);
      check("interference final", {hi, lo}, {32'd0, 32'd42});
      issue(MD_DIV, 32'd100, 32'd7, 32'd2, 32'd14);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      void'(exp_q.pop_back());
      exp_done--;
      @(negedge clk);
      check("abort busy/done", {62'd0, busy, done}, 64'd0);
      check("abort hi/lo", {hi, lo}, 64'd0);
      repeat (40) @(negedge clk);
      check("done count", 64'(n_done), 64'(exp_done));
      check("queue drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
